// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC spam trainer and classifier: token codes,
// trainer FSM states and the character-to-token mapping.
package hdc_pkg;

    localparam int NUM_CHAR       = 37;
    localparam int TOK_DIGIT_BASE = 1;
    localparam int TOK_ALPHA_BASE = 11;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        SUM,
        UPDATE
    } state_t;

    // Upper case folds onto lower case; digits and letters get their own
    // rows and everything else shares row 0.
    function automatic logic [5:0] to_token(input logic [7:0] c);
        logic [7:0] low;
        low = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
        if (low >= 8'h61 && low <= 8'h7A)
            return 6'(low - 8'h61) + 6'(TOK_ALPHA_BASE);
        if (low >= 8'h30 && low <= 8'h39)
            return 6'(low - 8'h30) + 6'(TOK_DIGIT_BASE);
        return 6'd0;
    endfunction

endpackage

// File: rtl/hdc_sat_acc.sv
// Signed accumulator step by -1, 0 or +1, clamped symmetrically at
// +/-(2^(ACC_W-1)-1) so the most negative code is never produced.
module hdc_sat_acc #(
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [1:0]       delta,
    output logic signed [ACC_W-1:0] sum
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

    always_comb begin
        sum = acc;
        if ((delta == 2'sb01 && acc < SAT_MAX) || (delta == 2'sb11 && acc > SAT_MIN))
            sum = acc + {{(ACC_W-2){delta[1]}}, delta};
    end

endmodule

// File: rtl/hdc_class_trainer.sv
// Builds ham/spam class reference vectors: bundles item-memory rows per
// message, binarizes against the bundle mean and accumulates per class.
module hdc_class_trainer #(
    parameter int DIM        = 1024,
    parameter int NUM_CHAR   = hdc_pkg::NUM_CHAR,
    parameter int MAX_LENGTH = 160,
    parameter int CNT_W      = 8,
    parameter int ACC_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_char,
    input  logic                        in_last,
    input  logic                        in_label,
    output logic [$clog2(NUM_CHAR)-1:0] im_addr,
    input  logic [DIM-1:0]              im_rdata,
    input  logic                        clear_acc,
    input  logic                        rd_class,
    input  logic [$clog2(DIM)-1:0]      rd_idx,
    output logic signed [ACC_W-1:0]     rd_data,
    output logic                        rd_bit,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [15:0]                 n_ham,
    output logic [15:0]                 n_spam
);
    import hdc_pkg::*;

    localparam int IM_AW = $clog2(NUM_CHAR);
    localparam int IDX_W = $clog2(DIM);
    localparam int TOT_W = CNT_W + IDX_W;
    localparam int LEN_W = $clog2(MAX_LENGTH + 1);

    state_t                  state;
    logic                    label;
    logic                    pend;
    logic [LEN_W-1:0]        char_cnt;
    logic [IDX_W-1:0]        idx;
    logic [TOT_W-1:0]        total;
    logic [CNT_W-1:0]        cnt [DIM];
    logic signed [ACC_W-1:0] acc [2][DIM];
    logic                    accept;
    logic [TOT_W-1:0]        scaled;
    logic signed [1:0]       delta;
    logic signed [ACC_W-1:0] acc_next;

    assign im_addr = IM_AW'(to_token(in_char));
    assign accept  = in_valid & in_ready;

    // Mean comparison without division: cnt > total/DIM  <=>  cnt*DIM > total.
    assign scaled = TOT_W'(cnt[idx]) * TOT_W'(DIM);

    always_comb begin
        delta = 2'sb00;
        if (scaled > total)
            delta = 2'sb01;
        else if (scaled < total)
            delta = 2'sb11;
    end

    hdc_sat_acc #(.ACC_W(ACC_W)) u_sat_acc (
        .acc   (acc[label][idx]),
        .delta (delta),
        .sum   (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            label    <= 1'b0;
            pend     <= 1'b0;
            char_cnt <= '0;
            idx      <= '0;
            total    <= '0;
            n_ham    <= '0;
            n_spam   <= '0;
            rd_data  <= '0;
            rd_bit   <= 1'b0;
            for (int j = 0; j < DIM; j++) begin
                cnt[j]    <= '0;
                acc[0][j] <= '0;
                acc[1][j] <= '0;
            end
        end else begin
            done    <= 1'b0;
            pend    <= 1'b0;
            rd_data <= acc[rd_class][rd_idx];
            rd_bit  <= !acc[rd_class][rd_idx][ACC_W-1] && (acc[rd_class][rd_idx] != '0);

            // Item-memory data arrives one cycle after the character was accepted.
            if (pend)
                for (int j = 0; j < DIM; j++)
                    cnt[j] <= cnt[j] + CNT_W'(im_rdata[j]);

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (clear_acc) begin
                        n_ham  <= '0;
                        n_spam <= '0;
                        for (int j = 0; j < DIM; j++) begin
                            acc[0][j] <= '0;
                            acc[1][j] <= '0;
                        end
                    end
                    if (accept) begin
                        label    <= in_label;
                        total    <= '0;
                        overflow <= 1'b0;
                        char_cnt <= LEN_W'(1);
                        pend     <= 1'b1;
                        busy     <= 1'b1;
                        in_ready <= !in_last;
                        state    <= in_last ? DRAIN : ACCUM;
                        for (int j = 0; j < DIM; j++)
                            cnt[j] <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (char_cnt < LEN_W'(MAX_LENGTH)) begin
                            char_cnt <= char_cnt + LEN_W'(1);
                            pend     <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    idx   <= '0;
                    state <= SUM;
                end
                SUM: begin
                    total <= total + TOT_W'(cnt[idx]);
                    idx   <= idx + IDX_W'(1);
                    if (idx == IDX_W'(DIM - 1)) begin
                        idx   <= '0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    acc[label][idx] <= acc_next;
                    idx             <= idx + IDX_W'(1);
                    if (idx == IDX_W'(DIM - 1)) begin
                        idx      <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                        if (label) begin
                            if (n_ham != 16'hFFFF)
                                n_ham <= n_ham + 16'd1;
                        end else if (n_spam != 16'hFFFF) begin
                            n_spam <= n_spam + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_class_trainer.sv
// Directed bench for hdc_class_trainer at DIM=8, ACC_W=4, MAX_LENGTH=4 with a
// small registered item-memory model; expectations are hand-computed.
module tb_hdc_class_trainer;

    localparam int DIM = 8;
    localparam int LAT = 2 * DIM + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_last, in_label;
    logic [7:0]  in_char;
    logic [5:0]  im_addr;
    logic [DIM-1:0] im_rdata;
    logic        clear_acc, rd_class;
    logic [2:0]  rd_idx;
    logic signed [3:0] rd_data;
    logic        rd_bit, busy, done, overflow;
    logic [15:0] n_ham, n_spam;

    logic [DIM-1:0] im_mem [64];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [47:0] text;
        int          len;
        bit          label;
        bit          hold;
        logic [31:0] exp_ham;
        logic [31:0] exp_spam;
        int          exp_nham;
        int          exp_nspam;
        bit          exp_ovf;
    } msg_vec_t;

    typedef struct {
        logic [7:0] ch;
        int         tok;
    } tok_vec_t;

    msg_vec_t msgs [6];
    tok_vec_t toks [8];

    hdc_class_trainer #(
        .DIM(DIM), .NUM_CHAR(37), .MAX_LENGTH(4), .CNT_W(8), .ACC_W(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_last(in_last), .in_label(in_label),
        .im_addr(im_addr), .im_rdata(im_rdata), .clear_acc(clear_acc),
        .rd_class(rd_class), .rd_idx(rd_idx), .rd_data(rd_data), .rd_bit(rd_bit),
        .busy(busy), .done(done), .overflow(overflow), .n_ham(n_ham), .n_spam(n_spam)
    );

    always #5 clk = ~clk;

    always @(posedge clk) im_rdata <= im_mem[im_addr];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reads all dimensions of one class; nibble j of exp is dimension j.
    task automatic check_acc(input bit cls, input logic [31:0] exp, input string tag);
        logic signed [3:0] nib;
        for (int j = 0; j < DIM; j++) begin
            rd_class = cls;
            rd_idx   = 3'(j);
            @(posedge clk); #1;
            nib = exp[4*j +: 4];
            check_output($sformatf("%s_data[%0d]", tag, j), int'(rd_data), int'(nib));
            check_output($sformatf("%s_bit[%0d]", tag, j), int'(rd_bit), int'(nib > 0));
        end
    endtask

    task automatic apply_stimulus(input msg_vec_t v, output int lat, output bit ready_ok);
        for (int w = 0; w < 10 && !in_ready; w++) begin
            @(posedge clk); #1;
        end
        check_output("ready_before_msg", int'(in_ready), 1);
        for (int k = 0; k < v.len; k++) begin
            in_valid = 1'b1;
            in_char  = v.text[8*(v.len-1-k) +: 8];
            in_last  = (k == v.len - 1);
            in_label = v.label;
            @(posedge clk); #1;
        end
        in_valid = v.hold;
        in_last  = 1'b0;
        lat      = 1;
        ready_ok = 1'b1;
        while (!done && lat < 100) begin
            if (in_ready) ready_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input int i);
        int lat;
        bit ready_ok;
        apply_stimulus(msgs[i], lat, ready_ok);
        check_output($sformatf("latency_%0d", i), lat, LAT);
        check_output($sformatf("ready_low_%0d", i), int'(ready_ok), 1);
        check_output($sformatf("overflow_%0d", i), int'(overflow), int'(msgs[i].exp_ovf));
        check_output($sformatf("n_ham_%0d", i), int'(n_ham), msgs[i].exp_nham);
        check_output($sformatf("n_spam_%0d", i), int'(n_spam), msgs[i].exp_nspam);
        @(posedge clk); #1;
        check_output($sformatf("done_pulse_%0d", i), int'(done), 0);
        check_output($sformatf("busy_idle_%0d", i), int'(busy), 0);
        check_acc(1'b1, msgs[i].exp_ham, $sformatf("ham_%0d", i));
        check_acc(1'b0, msgs[i].exp_spam, $sformatf("spam_%0d", i));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        bit ready_ok;
        bit saw_done;

        for (int a = 0; a < 64; a++) im_mem[a] = '0;
        im_mem[1]  = 8'hFF;
        im_mem[11] = 8'h0F;
        im_mem[12] = 8'h33;

        toks[0] = '{8'h41, 11};  toks[1] = '{8'h7A, 36};
        toks[2] = '{8'h30, 1};   toks[3] = '{8'h39, 10};
        toks[4] = '{8'h20, 0};   toks[5] = '{8'h5A, 36};
        toks[6] = '{8'h40, 0};   toks[7] = '{8'h5B, 0};

        msgs[0] = '{48'("A"), 1, 1'b1, 1'b0, 32'hFFFF1111, 32'h00000000, 1, 0, 1'b0};
        msgs[1] = '{48'("ab"), 2, 1'b0, 1'b0, 32'hFFFF1111, 32'hFF000011, 1, 1, 1'b0};
        msgs[2] = '{48'("0"), 1, 1'b1, 1'b0, 32'hFFFF1111, 32'hFF000011, 2, 1, 1'b0};
        msgs[3] = '{48'("aaaaaa"), 6, 1'b0, 1'b1, 32'hFFFF1111, 32'hEEFF1122, 2, 2, 1'b1};
        msgs[4] = '{48'("0"), 1, 1'b1, 1'b0, 32'hFFFF1111, 32'hEEFF1122, 3, 2, 1'b0};
        msgs[5] = '{48'("A"), 1, 1'b1, 1'b0, 32'hFFFF1111, 32'h00000000, 1, 0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0;
        in_label = 1'b0; clear_acc = 1'b0; rd_class = 1'b0; rd_idx = '0;
        #12;
        check_output("rst_in_ready", int'(in_ready), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_overflow", int'(overflow), 0);
        check_output("rst_rd_data", int'(rd_data), 0);
        check_output("rst_rd_bit", int'(rd_bit), 0);
        check_output("rst_im_addr", int'(im_addr), 0);
        check_output("rst_n_ham", int'(n_ham), 0);
        check_output("rst_n_spam", int'(n_spam), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_output("idle_ready", int'(in_ready), 1);

        for (int t = 0; t < 8; t++) begin
            in_char = toks[t].ch;
            #1;
            check_output($sformatf("token_%0d", t), int'(im_addr), toks[t].tok);
        end
        in_char = 8'h00;
        @(posedge clk); #1;

        // Ten identical ham messages push every dimension into saturation.
        for (int n = 0; n < 10; n++) begin
            apply_stimulus(msgs[0], lat, ready_ok);
            check_output($sformatf("sat_latency_%0d", n), lat, LAT);
        end
        @(posedge clk); #1;
        check_output("sat_n_ham", int'(n_ham), 10);
        check_acc(1'b1, 32'h99997777, "sat_ham");

        clear_acc = 1'b1;
        @(posedge clk); #1;
        clear_acc = 1'b0;
        check_output("clr_n_ham", int'(n_ham), 0);
        check_output("clr_n_spam", int'(n_spam), 0);
        check_acc(1'b1, 32'h0, "clr_ham");
        check_acc(1'b0, 32'h0, "clr_spam");

        for (int i = 0; i < 5; i++) run_vector(i);

        // Reset lands while the ham accumulator is being updated at dimension 3.
        in_valid = 1'b1; in_char = 8'h41; in_last = 1'b1; in_label = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_output("mid_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_output("mid_busy", int'(busy), 0);
        check_output("mid_done", int'(done), 0);
        check_output("mid_in_ready", int'(in_ready), 0);
        check_output("mid_n_ham", int'(n_ham), 0);
        check_output("mid_n_spam", int'(n_spam), 0);
        check_output("mid_rd_data", int'(rd_data), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check_output("mid_no_done", int'(saw_done), 0);
        check_acc(1'b1, 32'h0, "mid_ham");
        check_acc(1'b0, 32'h0, "mid_spam");
        run_vector(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
